hazard_scoreboard_fwd: RTL and testbench
========================================

Name: hazard_scoreboard_fwd

Overview:
Parametrised forwarding and hazard controller for deeper MIPS pipeline variants. It tracks in-flight register writes in a DEPTH-entry destination shift register, one entry per post-decode stage. For NRP source operands in decode it selects the youngest forwarding stage. It raises a load-use stall whenever the producing load's data is not yet available. Instantiated once per pipeline; it drives the operand bypass muxes and the IF/ID hold / ID/EX bubble logic.

Parameters:
AW, 5, register address width
NRP, 2, number of source-operand read ports checked
DEPTH, 3, tracked stages after decode (entry 0 = EX, 1 = MEM, 2 = WB, ...)
LOAD_LAT, 2, first entry index at which a load result is forwardable (2 = end of MEM)
SELW, $clog2(DEPTH+1), width of each forward-select field

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
issue_valid  in  1  decode instruction advances into EX this cycle
issue_rd  in  AW  destination register of issuing instruction
issue_we  in  1  issuing instruction writes a register
issue_load  in  1  issuing instruction is a load
stall_in  in  1  external freeze (memory wait); whole tracker holds
flush  in  1  kill the instruction entering EX (branch mispredict)
rs_addr  in  NRP*AW  decode source registers, port p at [p*AW +: AW]
rs_need  in  NRP  port p actually reads its register
fwd_sel  out  NRP*SELW  per port: 0 = register file, k = forward from entry k-1
stall_out  out  1  load-use hazard; hold decode, insert bubble
track_valid  out  DEPTH  per-entry valid, for debug/verification

Behaviour:
- State: DEPTH entries {v, rd, ld}. Only instructions with issue_we=1 and issue_rd!=0 are recorded with v=1; all others enter as bubbles (v=0).
- Reset: rst_n low at a clock edge clears every v, rd, and ld. While rst_n is low, fwd_sel=0, stall_out=0, and track_valid=0, forced combinationally.
- Update priority per clock edge:
  1. If stall_in=1, all entries hold. Exception: if flush=1, entry 0 also clears.
  2. Otherwise, entries shift: entry[i] <= entry[i-1] for i>=1. Entry 0 loads the issuing instruction if issue_valid & ~stall_out & ~flush; otherwise it loads a bubble.
  - The oldest entry drops off the end of the shift register.
- Latency: an instruction issued at edge t is visible in entry 0 (fwd_sel=1) from t+1, and in entry k from t+1+k if no freeze occurs.
- Forward select (combinational from state and rs inputs):
  - For port p with rs_need[p]=1 and rs_addr!=0, find the smallest i with v[i] & rd[i]==rs_addr[p]. The youngest match wins; older matches are ignored.
  - fwd_sel[p] = i+1 if a match exists, else 0.
- Load-use: stall_out=1 if any needed port's youngest match has ld=1 and i<LOAD_LAT. In that case that port's fwd_sel is still reported, but consumers must ignore it while stall_out=1.
- Register 0 never matches or stalls.
- stall_out is not registered; it deasserts the cycle the load reaches entry LOAD_LAT.
- stall_in=1 does not mask stall_out; both may be high together.
- Reset mid-operation discards all tracking; the first post-reset cycle has no forwarding.

Decomposition:
- Shared package hazard_pkg holds:
  - the entry struct/typedef {v, rd, ld};
  - the FWD_RF=0 select constant;
  - default AW, DEPTH, and LOAD_LAT values, shared with the datapath bypass muxes.
- One natural sub-module, fwd_match_port: a combinational priority match for a single read port, instantiated NRP times.
- The shift register and stall logic stay in the top module.

Test Plan:
- Back-to-back ALU dependency: issue rd=8 (we=1, ld=0) at t0; at t1 rs_addr[0]=8 -> fwd_sel[0]=1, stall_out=0. At t2 with no reissue -> fwd_sel[0]=2. At t3 -> fwd_sel[0]=3. At t4 -> 0.
- Load-use: issue a load with rd=9 at t0; at t1 rs_addr[1]=9 -> stall_out=1. Bubble inserted; at t2 entry 1 holds the load -> stall_out=1 (LOAD_LAT=2). At t3 -> stall_out=0, fwd_sel[1]=3.
- Youngest wins: issue rd=5 at t0 and again at t1; at t2 rs=5 -> fwd_sel=1, not 2. Same check with rs=0 and rd=0 issues -> fwd_sel=0, track_valid=000.
- Freeze and flush: issue rd=4 at t0, stall_in=1 on t1..t3 -> fwd_sel stays 1. Issue rd=6 with flush=1 -> entry 0 is a bubble and rs=6 gives 0.
- Reset mid-flight: three valid entries, rst_n=0 for one edge -> track_valid=000 and fwd_sel=0 on all ports. Also check outputs are forced to 0 while rst_n is low before the edge.
- Parameter sweep: NRP=3, DEPTH=5, LOAD_LAT=3. Repeat the load-use scenario -> stall for exactly 3 cycles. Check that all three ports match independently.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard scoreboard and the datapath bypass muxes.
package hazard_pkg;
  localparam int HZ_AW       = 5;
  localparam int HZ_DEPTH    = 3;
  localparam int HZ_LOAD_LAT = 2;
  localparam int FWD_RF      = 0;

  typedef struct packed {
    logic              v;
    logic [HZ_AW-1:0]  rd;
    logic              ld;
  } hz_entry_t;
endpackage

// File: rtl/fwd_match_port.sv
// Combinational youngest-match search for one read port; zero latency.
// Also flags a load-use hazard when the winning producer is a load that is not yet forwardable.
module fwd_match_port #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SELW     = $clog2(DEPTH+1)
) (
  input  logic [DEPTH-1:0]    ent_v_i,
  input  logic [DEPTH*AW-1:0] ent_rd_i,
  input  logic [DEPTH-1:0]    ent_ld_i,
  input  logic [AW-1:0]       rs_i,
  input  logic                need_i,
  output logic [SELW-1:0]     sel_o,
  output logic                haz_o
);
  always_comb begin
    sel_o = '0;
    haz_o = 1'b0;
    if (need_i && (rs_i != '0)) begin
      // Scan oldest to youngest so the youngest hit overwrites older ones.
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (ent_v_i[i] && (ent_rd_i[i*AW +: AW] == rs_i)) begin
          sel_o = SELW'(i+1);
          haz_o = ent_ld_i[i] && (i < LOAD_LAT);
        end
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard_fwd.sv
// Tracks in-flight writes per post-decode stage; drives bypass selects (comb) and load-use stall (comb).
// Entry 0 updates one edge after issue; stall_in freezes the whole tracker, flush bubbles entry 0.
module hazard_scoreboard_fwd
  import hazard_pkg::*;
#(
  parameter int AW       = HZ_AW,
  parameter int NRP      = 2,
  parameter int DEPTH    = HZ_DEPTH,
  parameter int LOAD_LAT = HZ_LOAD_LAT,
  parameter int SELW     = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                issue_we,
  input  logic                issue_load,
  input  logic                stall_in,
  input  logic                flush,
  input  logic [NRP*AW-1:0]   rs_addr,
  input  logic [NRP-1:0]      rs_need,
  output logic [NRP*SELW-1:0] fwd_sel,
  output logic                stall_out,
  output logic [DEPTH-1:0]    track_valid
);
  hz_entry_t [DEPTH-1:0] ent_q, ent_d;
  hz_entry_t             new_ent;

  logic [DEPTH-1:0]    ent_v, ent_ld;
  logic [DEPTH*AW-1:0] ent_rd;
  logic [NRP*SELW-1:0] sel_raw;
  logic [NRP-1:0]      haz;
  logic                stall_raw;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_v[i]            = ent_q[i].v;
      ent_ld[i]           = ent_q[i].ld;
      ent_rd[i*AW +: AW]  = ent_q[i].rd;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_port
    fwd_match_port #(
      .AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)
    ) u_match (
      .ent_v_i  (ent_v),
      .ent_rd_i (ent_rd),
      .ent_ld_i (ent_ld),
      .rs_i     (rs_addr[p*AW +: AW]),
      .need_i   (rs_need[p]),
      .sel_o    (sel_raw[p*SELW +: SELW]),
      .haz_o    (haz[p])
    );
  end

  assign stall_raw = |haz;

  always_comb begin
    new_ent = '0;
    if (issue_valid && !stall_raw && !flush && issue_we && (issue_rd != '0)) begin
      new_ent.v  = 1'b1;
      new_ent.rd = issue_rd;
      new_ent.ld = issue_load;
    end
    ent_d = ent_q;
    if (stall_in) begin
      if (flush) ent_d[0] = '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) ent_d[i] = ent_q[i-1];
      ent_d[0] = new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  // Outputs are masked during reset so consumers see a clean tracker immediately.
  assign fwd_sel     = rst_n ? sel_raw : '0;
  assign stall_out   = rst_n & stall_raw;
  assign track_valid = rst_n ? ent_v : '0;
endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// Directed bench for the hazard scoreboard: default config plus a wider/deeper sweep instance.
module tb_hazard_scoreboard_fwd;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Default instance: AW=5 NRP=2 DEPTH=3 LOAD_LAT=2 SELW=2
  logic       iv, iwe, ild, sin, fl;
  logic [4:0] ird;
  logic [9:0] rs;
  logic [1:0] need;
  logic [3:0] fsel;
  logic       so;
  logic [2:0] tv;

  hazard_scoreboard_fwd u_dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv), .issue_rd(ird), .issue_we(iwe),
    .issue_load(ild), .stall_in(sin), .flush(fl), .rs_addr(rs), .rs_need(need),
    .fwd_sel(fsel), .stall_out(so), .track_valid(tv)
  );

  // Sweep instance: NRP=3 DEPTH=5 LOAD_LAT=3 SELW=3
  logic        b_iv, b_iwe, b_ild, b_sin, b_fl;
  logic [4:0]  b_ird;
  logic [14:0] b_rs;
  logic [2:0]  b_need;
  logic [8:0]  b_fsel;
  logic        b_so;
  logic [4:0]  b_tv;

  hazard_scoreboard_fwd #(.AW(5), .NRP(3), .DEPTH(5), .LOAD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .issue_valid(b_iv), .issue_rd(b_ird), .issue_we(b_iwe),
    .issue_load(b_ild), .stall_in(b_sin), .flush(b_fl), .rs_addr(b_rs), .rs_need(b_need),
    .fwd_sel(b_fsel), .stall_out(b_so), .track_valid(b_tv)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic load);
    iv = 1'b1; iwe = 1'b1; ird = rd; ild = load;
  endtask

  task automatic idle(input int n);
    iv = 1'b0; iwe = 1'b0; ild = 1'b0; ird = '0; sin = 1'b0; fl = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = 0; iwe = 0; ild = 0; ird = 0; sin = 0; fl = 0; rs = '0; need = '0;
    b_iv = 0; b_iwe = 0; b_ild = 0; b_ird = 0; b_sin = 0; b_fl = 0; b_rs = '0; b_need = '0;
    step(); step();
    n_total++; if (tv !== 3'b000) $display("FAIL reset_tv got=%b exp=000", tv); else n_pass++;
    n_total++; if (so !== 1'b0) $display("FAIL reset_stall got=%b exp=0", so); else n_pass++;
    n_total++; if (b_tv !== 5'b0) $display("FAIL reset_b_tv got=%b exp=00000", b_tv); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    issue(5'd8, 1'b0);
    step();
    iv = 0; iwe = 0;
    rs[4:0] = 5'd8; need = 2'b01; #1;
    n_total++; if (fsel[1:0] !== 2'd1 || so !== 1'b0) $display("FAIL alu_t1 sel=%0d stall=%b exp sel=1 stall=0", fsel[1:0], so); else n_pass++;
    n_total++; if (tv !== 3'b001) $display("FAIL alu_t1_tv got=%b exp=001", tv); else n_pass++;
    step();
    n_total++; if (fsel[1:0] !== 2'd2) $display("FAIL alu_t2 got=%0d exp=2", fsel[1:0]); else n_pass++;
    step();
    n_total++; if (fsel[1:0] !== 2'd3) $display("FAIL alu_t3 got=%0d exp=3", fsel[1:0]); else n_pass++;
    step();
    n_total++; if (fsel[1:0] !== 2'd0 || tv !== 3'b000) $display("FAIL alu_t4 sel=%0d tv=%b exp sel=0 tv=000", fsel[1:0], tv); else n_pass++;
    need = 2'b00;
  endtask

  task automatic test_load_use();
    issue(5'd9, 1'b1);
    step();
    issue(5'd10, 1'b0);
    rs[9:5] = 5'd9; need = 2'b10; #1;
    n_total++; if (so !== 1'b1 || fsel[3:2] !== 2'd1) $display("FAIL lu_t1 stall=%b sel=%0d exp stall=1 sel=1", so, fsel[3:2]); else n_pass++;
    step();
    n_total++; if (so !== 1'b1 || tv !== 3'b010) $display("FAIL lu_t2 stall=%b tv=%b exp stall=1 tv=010", so, tv); else n_pass++;
    step();
    n_total++; if (so !== 1'b0 || fsel[3:2] !== 2'd3) $display("FAIL lu_t3 stall=%b sel=%0d exp stall=0 sel=3", so, fsel[3:2]); else n_pass++;
    step();
    need = 2'b00; #1;
    n_total++; if (tv !== 3'b001) $display("FAIL lu_dep_issued tv=%b exp=001", tv); else n_pass++;
    idle(3);
  endtask

  task automatic test_youngest();
    issue(5'd5, 1'b0); step();
    issue(5'd5, 1'b0); step();
    iv = 0; iwe = 0;
    rs[4:0] = 5'd5; need = 2'b01; #1;
    n_total++; if (fsel[1:0] !== 2'd1 || tv !== 3'b011) $display("FAIL youngest sel=%0d tv=%b exp sel=1 tv=011", fsel[1:0], tv); else n_pass++;
    need = 2'b00; #1;
    n_total++; if (fsel[1:0] !== 2'd0) $display("FAIL unneeded_port got=%0d exp=0", fsel[1:0]); else n_pass++;
    idle(3);
    issue(5'd0, 1'b0); step();
    issue(5'd0, 1'b1); step();
    iv = 0; iwe = 0; ild = 0;
    rs[4:0] = 5'd0; need = 2'b01; #1;
    n_total++; if (fsel[1:0] !== 2'd0 || tv !== 3'b000 || so !== 1'b0) $display("FAIL r0 sel=%0d tv=%b stall=%b exp 0/000/0", fsel[1:0], tv, so); else n_pass++;
    need = 2'b00;
    idle(3);
  endtask

  task automatic test_freeze_flush();
    issue(5'd4, 1'b0); step();
    iv = 0; iwe = 0; sin = 1'b1;
    rs[4:0] = 5'd4; need = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++; if (fsel[1:0] !== 2'd1) $display("FAIL freeze_%0d got=%0d exp=1", k, fsel[1:0]); else n_pass++;
    end
    sin = 1'b0;
    issue(5'd6, 1'b0); fl = 1'b1; step();
    fl = 1'b0; iv = 0; iwe = 0;
    rs[4:0] = 5'd6; #1;
    n_total++; if (fsel[1:0] !== 2'd0 || tv !== 3'b010) $display("FAIL flush sel=%0d tv=%b exp sel=0 tv=010", fsel[1:0], tv); else n_pass++;
    issue(5'd7, 1'b0); step();
    iv = 0; iwe = 0; sin = 1'b1; fl = 1'b1; step();
    sin = 1'b0; fl = 1'b0;
    rs[4:0] = 5'd4; #1;
    n_total++; if (tv !== 3'b100 || fsel[1:0] !== 2'd3) $display("FAIL freeze_flush tv=%b sel=%0d exp tv=100 sel=3", tv, fsel[1:0]); else n_pass++;
    need = 2'b00;
    idle(3);
  endtask

  task automatic test_reset_midflight();
    issue(5'd1, 1'b0); step();
    issue(5'd2, 1'b0); step();
    issue(5'd3, 1'b1); step();
    iv = 0; iwe = 0; ild = 0;
    rs[4:0] = 5'd1; rs[9:5] = 5'd3; need = 2'b11; sin = 1'b1; #1;
    n_total++; if (tv !== 3'b111 || fsel !== 4'b0111 || so !== 1'b1) $display("FAIL pre_reset tv=%b sel=%b stall=%b exp 111/0111/1", tv, fsel, so); else n_pass++;
    sin = 1'b0;
    rst_n = 1'b0; #1;
    n_total++; if (tv !== 3'b000 || fsel !== 4'b0 || so !== 1'b0) $display("FAIL reset_forced tv=%b sel=%b stall=%b exp 000/0000/0", tv, fsel, so); else n_pass++;
    step();
    rst_n = 1'b1; #1;
    n_total++; if (tv !== 3'b000 || fsel !== 4'b0 || so !== 1'b0) $display("FAIL post_reset tv=%b sel=%b stall=%b exp 000/0000/0", tv, fsel, so); else n_pass++;
    need = 2'b00;
    idle(1);
  endtask

  task automatic test_param_sweep();
    b_iv = 1; b_iwe = 1; b_ird = 5'd9; b_ild = 1; step();
    b_ird = 5'd10; b_ild = 0;
    b_rs[9:5] = 5'd9; b_need = 3'b010;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (b_so !== 1'b1) $display("FAIL sweep_stall_%0d got=%b exp=1", k, b_so); else n_pass++;
      step();
    end
    n_total++; if (b_so !== 1'b0 || b_fsel[5:3] !== 3'd4) $display("FAIL sweep_release stall=%b sel=%0d exp stall=0 sel=4", b_so, b_fsel[5:3]); else n_pass++;
    b_ird = 5'd11; step();
    b_ird = 5'd12; step();
    b_ird = 5'd13; step();
    b_iv = 0; b_iwe = 0;
    b_rs = {5'd13, 5'd12, 5'd11}; b_need = 3'b111; #1;
    n_total++; if (b_fsel !== {3'd1, 3'd2, 3'd3}) $display("FAIL sweep_ports got=%o exp=123", b_fsel); else n_pass++;
    b_need = 3'b011; #1;
    n_total++; if (b_fsel !== {3'd0, 3'd2, 3'd3}) $display("FAIL sweep_need got=%o exp=023", b_fsel); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_freeze_flush();
    test_reset_midflight();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
